// File: rtl/spi_mul_pkg.sv
// Shared types and constants for the SPI multiplier slave.
// SPI_MUL_SLV_CHK_EN adds a trailing checksum byte to the frame.
package spi_mul_pkg;

`ifdef SPI_MUL_SLV_CHK_EN
    typedef enum logic [2:0] {
        IDLE, RX_A, RX_B, MUL, TX_HI, TX_LO, TX_CHK, TRAIL
    } state_e;
    localparam int FRAME_BYTES = 5;
`else
    typedef enum logic [2:0] {
        IDLE, RX_A, RX_B, MUL, TX_HI, TX_LO, TRAIL
    } state_e;
    localparam int FRAME_BYTES = 4;
`endif

    localparam logic [7:0] IDLE_FILL_DEF = 8'hFF;

    function automatic logic [7:0] chk_byte(
        input logic [7:0]  a,
        input logic [7:0]  b,
        input logic [15:0] p
    );
        return a ^ b ^ p[15:8] ^ p[7:0];
    endfunction

endpackage

// File: rtl/spi_slv_sync_edge.sv
// N-stage synchronizer with rise/fall pulses from the last two
// synchronized samples.
module spi_slv_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_mul_slave.sv
// SPI mode-0 slave: receives A and B, returns A*B in the same frame.
// SPI_MUL_SLV_CHK_EN appends a checksum byte after the product.
module spi_mul_slave
    import spi_mul_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = IDLE_FILL_DEF
) (
    input  logic                  clk_int,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_bar,
    input  logic                  din_mosi,
    output logic                  dout_miso,
    output logic                  miso_oe,
    output logic                  rx_valid,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [2*DATA_W-1:0]   product
);

    localparam int            CW   = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   rx_q, rx_d, tx_q, tx_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic                rxv_q, rxv_d, done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0]   rx_byte, next_tx;
    logic                byte_done;

    spi_slv_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk_i  (clk_int),
        .rst_i  (reset),
        .d_i    (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_slv_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk_i  (clk_int),
        .rst_i  (reset),
        .d_i    (cs_bar),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign rx_byte   = {rx_q[DATA_W-2:0], mosi_s};
    assign byte_done = sclk_rise && (cnt_q == LAST);

    // Byte loaded at the fall that closes a byte, keyed by the new state
    always_comb begin
        next_tx = '0;
        case (state_q)
            TX_HI:   next_tx = tx_q;
            TX_LO:   next_tx = prod_q[DATA_W-1:0];
`ifdef SPI_MUL_SLV_CHK_EN
            TX_CHK:  next_tx = chk_byte(a_q, b_q, prod_q);
`endif
            TRAIL:   next_tx = IDLE_FILL;
            default: next_tx = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        rxv_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (cs_rise) begin
            if (state_q != IDLE) begin
                err_d   = (state_q != TRAIL);
                state_d = IDLE;
                cnt_d   = '0;
                rx_d    = '0;
                tx_d    = '0;
            end
        end else if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d = RX_A;
                cnt_d   = '0;
                rx_d    = '0;
                tx_d    = '0;
            end
        end else begin
            if (sclk_rise) begin
                rx_d  = rx_byte;
                cnt_d = cnt_q + 1'b1;
            end
            if (sclk_fall) begin
                tx_d = (cnt_q == '0) ? next_tx
                                     : {tx_q[DATA_W-2:0], 1'b0};
            end
            rxv_d = byte_done;
            case (state_q)
                RX_A: if (byte_done) begin
                    a_d     = rx_byte;
                    state_d = RX_B;
                end
                RX_B: if (byte_done) begin
                    b_d     = rx_byte;
                    state_d = MUL;
                end
                MUL: begin
                    prod_d  = {{DATA_W{1'b0}}, a_q}
                            * {{DATA_W{1'b0}}, b_q};
                    tx_d    = prod_d[2*DATA_W-1:DATA_W];
                    state_d = TX_HI;
                end
                TX_HI: if (byte_done) state_d = TX_LO;
`ifdef SPI_MUL_SLV_CHK_EN
                TX_LO: if (byte_done) state_d = TX_CHK;
                TX_CHK: if (byte_done) begin
                    state_d = TRAIL;
                    done_d  = 1'b1;
                end
`else
                TX_LO: if (byte_done) begin
                    state_d = TRAIL;
                    done_d  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            mosi_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            rxv_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mosi_q  <= {mosi_q[SYNC_STAGES-2:0], din_mosi};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            rxv_q   <= rxv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign miso_oe    = (state_q != IDLE);
    assign dout_miso  = miso_oe & tx_q[DATA_W-1];
    assign rx_valid   = rxv_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign product    = prod_q;

endmodule

// File: tb/tb_spi_mul_slave.sv
// Directed and randomized frames against an arithmetic reference model.
module tb_spi_mul_slave;

`ifdef SPI_MUL_SLV_CHK_EN
    localparam int FB = 5;
`else
    localparam int FB = 4;
`endif

    logic        clk = 1'b0;
    logic        reset, sclk, cs_bar, mosi;
    logic        dout_miso, miso_oe, rx_valid, frame_done, frame_err;
    logic [15:0] product;

    int total = 0;
    int bad   = 0;
    int rxv_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [15:0] prod_exp = 16'h0;

    spi_mul_slave dut (
        .clk_int    (clk),
        .reset      (reset),
        .sclk       (sclk),
        .cs_bar     (cs_bar),
        .din_mosi   (mosi),
        .dout_miso  (dout_miso),
        .miso_oe    (miso_oe),
        .rx_valid   (rx_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .product    (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid)   rxv_cnt  <= rxv_cnt + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            repeat (5) @(negedge clk);
            rx = {rx[6:0], dout_miso};
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             input int nb);
        logic [7:0]  exp_q[$];
        logic [15:0] p;
        logic [7:0]  tx, got;
        int rx0, dn0, er0;
        p = 16'(a) * 16'(b);
        exp_q = '{8'h00, 8'h00, p[15:8], p[7:0]};
`ifdef SPI_MUL_SLV_CHK_EN
        exp_q.push_back(a ^ b ^ p[15:8] ^ p[7:0]);
`endif
        while (exp_q.size() < nb) exp_q.push_back(8'hFF);
        rx0 = rxv_cnt; dn0 = done_cnt; er0 = err_cnt;
        cs_bar = 1'b0;
        repeat (10) @(negedge clk);
        chk("oe_frame", 32'(miso_oe), 32'd1);
        for (int i = 0; i < nb; i++) begin
            tx = (i == 0) ? a : (i == 1) ? b : 8'($urandom);
            spi_bits(tx, 8, got);
            chk($sformatf("miso_b%0d", i), 32'(got), 32'(exp_q[i]));
            chk("rxv_cnt", 32'(rxv_cnt - rx0), 32'(i + 1));
            chk("done_cnt", 32'(done_cnt - dn0),
                (i >= FB - 1) ? 32'd1 : 32'd0);
            if (i == 1) chk("prod_early", 32'(product), 32'(p));
        end
        repeat (5) @(negedge clk);
        cs_bar = 1'b1;
        repeat (10) @(negedge clk);
        chk("err_none", 32'(err_cnt - er0), 32'd0);
        chk("prod", 32'(product), 32'(p));
        chk("oe_idle", 32'({miso_oe, dout_miso}), 32'd0);
        prod_exp = p;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got, a, b;
        int er0, rx0;
        reset = 1'b1; sclk = 1'b0; cs_bar = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("in_reset", 32'({dout_miso, miso_oe, rx_valid, frame_done,
                             frame_err, product}), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_reset", 32'({dout_miso, miso_oe, rx_valid,
                                   frame_done, frame_err, product}), 32'd0);
        end

        run_frame(8'h0C, 8'h0B, FB);
        run_frame(8'hFF, 8'hFF, 6);

        er0 = err_cnt; rx0 = rxv_cnt;
        cs_bar = 1'b0;
        repeat (10) @(negedge clk);
        spi_bits(8'h12, 8, got);
        spi_bits(8'h34, 4, got);
        repeat (5) @(negedge clk);
        cs_bar = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_err", 32'(err_cnt - er0), 32'd1);
        chk("abort_rxv", 32'(rxv_cnt - rx0), 32'd1);
        chk("abort_prod", 32'(product), 32'(prod_exp));
        run_frame(8'h03, 8'h05, FB);

        cs_bar = 1'b0;
        repeat (10) @(negedge clk);
        spi_bits(8'h21, 8, got);
        spi_bits(8'h43, 8, got);
        spi_bits(8'h00, 3, got);
        chk("mid_oe", 32'(miso_oe), 32'd1);
        #2 reset = 1'b1;
        #1 chk("async_rst", 32'({dout_miso, miso_oe, rx_valid, frame_done,
                                 frame_err, product}), 32'd0);
        cs_bar = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        prod_exp = 16'h0;
        repeat (5) @(negedge clk);
        chk("rst_prod", 32'(product), 32'(prod_exp));
        run_frame(8'h02, 8'h80, FB);

        for (int k = 0; k < 5; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            run_frame(a, b, FB + int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
